// File: rtl/counter.sv
// rtl/counter.sv - free-running synchronous up-counter, wraps modulo MODULUS
module counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2 ** WIDTH,
    parameter int INIT    = 0
) (
    input  logic             ck,
    input  logic             res,
    output logic [WIDTH-1:0] q
);

    // Reset value and last count value before the wrap, both at counter width
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] LAST_V = WIDTH'(MODULUS - 1);

    // A full-range modulus wraps by natural overflow, so no compare is needed
    localparam bit FULL_RANGE = (MODULUS == (2 ** WIDTH));

    logic [WIDTH-1:0] q_inc;
    logic [WIDTH-1:0] q_next;

    assign q_inc = q + WIDTH'(1);

    generate
        if (FULL_RANGE) begin : g_natural_wrap
            // Overflow from all-ones to zero is the wrap
            always_comb begin
                q_next = q_inc;
            end
        end else begin : g_compare_wrap
            // Explicit wrap to zero at MODULUS-1
            always_comb begin
                q_next = q_inc;
                if (q == LAST_V) begin
                    q_next = '0;
                end
            end
        end
    endgenerate

    // Count register; res is sampled only at the rising edge and wins over counting
    always_ff @(posedge ck) begin
        if (!res) begin
            q <= INIT_V;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: tb/tb_counter.sv
// tb/tb_counter.sv - self-checking bench for counter
`timescale 1ns/1ps
module tb_counter;

    localparam int WIDTH   = 4;
    localparam int MODULUS = 16;
    localparam int INIT    = 0;

    logic             ck;
    logic             res;
    logic [WIDTH-1:0] q;

    int tests_run;
    int tests_failed;
    int model_q;

    typedef struct {
        logic             res;
        logic [WIDTH-1:0] exp_q;
    } vec_t;

    vec_t vecs[25];

    counter #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS),
        .INIT    (INIT)
    ) dut (
        .ck  (ck),
        .res (res),
        .q   (q)
    );

    initial ck = 1'b0;
    always #50 ck = ~ck;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: q=%h expected %h", name, act, exp);
        end
    endtask

    // Drive res away from the edge, let one rising edge pass, sample on the falling edge
    task automatic step(input logic r);
        res = r;
        @(posedge ck);
        @(negedge ck);
    endtask

    // Reference: reset loads INIT, otherwise next value is (q+1) mod MODULUS
    task automatic model_step(input logic r);
        if (!r) model_q = INIT;
        else    model_q = (model_q + 1) % MODULUS;
    endtask

    initial begin
        logic r;
        tests_run    = 0;
        tests_failed = 0;
        model_q      = INIT;
        res          = 1'b0;

        // Power-up, release and wrap: one reset edge then 24 counting edges
        vecs[0].res   = 1'b0;
        vecs[0].exp_q = WIDTH'(INIT);
        for (int i = 1; i < 25; i++) begin
            vecs[i].res   = 1'b1;
            vecs[i].exp_q = WIDTH'((INIT + i) % MODULUS);
        end
        for (int i = 0; i < 25; i++) begin
            step(vecs[i].res);
            check($sformatf("table[%0d]", i), q, vecs[i].exp_q);
        end

        // Mid-count reset at q=9
        step(1'b0);
        for (int i = 1; i <= 9; i++) step(1'b1);
        check("reach_9", q, 4'h9);
        step(1'b0);
        check("mid_reset", q, 4'h0);
        step(1'b1);
        check("mid_release", q, 4'h1);

        // Reset glitch between edges must be ignored (q now 1, next edge -> 2)
        res = 1'b1;
        #20 res = 1'b0;
        #20 res = 1'b1;
        @(posedge ck);
        @(negedge ck);
        check("glitch_ignored", q, 4'h2);
        step(1'b1);
        check("glitch_after", q, 4'h3);

        // Reset at the wrap point
        while (q != 4'hf) step(1'b1);
        step(1'b0);
        check("reset_at_wrap", q, 4'h0);

        // Held reset for three edges, then release
        step(1'b1);
        step(1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            check($sformatf("held_reset[%0d]", i), q, 4'h0);
        end
        step(1'b1);
        check("held_release", q, 4'h1);

        // Randomised res against the reference model
        model_q = 1;
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 9) != 0);
            step(r);
            model_step(r);
            check($sformatf("random[%0d]", i), q, WIDTH'(model_q));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
